// File: rtl/gf2_poly_pkg.sv
// Shared parameters and state encoding for the bit-serial GF(2)[x] long divider.
// The counter width is derived from the operand width so the two cannot drift apart.
package gf2_poly_pkg;

  localparam int WIDTH_DEF = 224;

  function automatic int cnt_w(input int width);
    return $clog2(2 * width);
  endfunction

  localparam int CNT_W_DEF = cnt_w(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2
  } state_t;

endpackage

// File: rtl/leading_one_detector.sv
// Combinational priority encoder: index of the most significant set bit plus an all-zero flag.
module leading_one_detector #(
  parameter int N     = 225,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             zero
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    idx  = '0;
    zero = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx  = IDX_W'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2)[x] long divider: 2*WIDTH-bit dividend by a divisor of degree <= WIDTH,
// one quotient bit per clock, with a start/busy/done handshake.
module gf2_poly_divider
  import gf2_poly_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH:0]       divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero,
  output logic [2*WIDTH-1:0]   q,
  output logic [WIDTH-1:0]     r
);

  localparam int DEG_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] dvd;
  logic [WIDTH-1:0]   dvs;
  logic [DEG_W-1:0]   deg;
  logic [WIDTH-1:0]   rem;

  logic [DEG_W-1:0]   lod_idx;
  logic               lod_zero;
  logic [WIDTH:0]     rem_shift;
  logic               hit;
  logic [WIDTH-1:0]   rem_next;

  leading_one_detector #(
    .N    (WIDTH + 1),
    .IDX_W(DEG_W)
  ) u_lod (
    .vec (divisor),
    .idx (lod_idx),
    .zero(lod_zero)
  );

  // The divisor's leading term always cancels the shifted remainder's bit deg, so only the bits
  // below WIDTH are kept; the remainder's top bit is identically zero after every step.
  always_comb begin
    rem_shift = {rem, dvd[cnt]};
    hit       = rem_shift[deg];
    rem_next  = rem_shift[WIDTH-1:0] ^ (hit ? dvs : '0);
  end

  // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      deg      <= '0;
      rem      <= '0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            div_zero <= 1'b0;
            if (lod_zero) begin
              state <= ZERO;
            end else begin
              dvd   <= dividend;
              dvs   <= divisor[WIDTH-1:0];
              deg   <= lod_idx;
              rem   <= '0;
              q     <= '0;
              cnt   <= CNT_W'(2 * WIDTH - 1);
              state <= RUN;
            end
          end
        end

        RUN: begin
          rem    <= rem_next;
          q[cnt] <= hit;
          if (cnt == '0) begin
            r     <= rem_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ZERO: begin
          q        <= '0;
          r        <= '0;
          div_zero <= 1'b1;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Directed and round-trip checks for gf2_poly_divider against hand-computed values and a
// carry-less multiply reference.
module tb_gf2_poly_divider;

  localparam int W = 224;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W:0]     divisor;
  logic           busy;
  logic           done;
  logic           div_zero;
  logic [2*W-1:0] q;
  logic [W-1:0]   r;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  gf2_poly_divider #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dividend(dividend),
    .divisor (divisor),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .q       (q),
    .r       (r)
  );

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] rand224();
    logic [W-1:0] v = '0;
    for (int i = 0; i < 7; i++) v = {v[W-33:0], 32'($urandom())};
    return v;
  endfunction

  function automatic logic [2*W-1:0] clmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p  = '0;
    logic [2*W-1:0] aw = {{W{1'b0}}, a};
    for (int i = 0; i < W; i++) if (b[i]) p ^= aw << i;
    return p;
  endfunction

  // Present operands at the falling edge; return just after the accepting rising edge.
  task automatic start_op(input logic [2*W-1:0] a, input logic [W:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (done !== 1'b1 && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [2*W-1:0] a, input logic [W:0] b, output int lat);
    start_op(a, b);
    wait_done(0, lat);
  endtask

  initial begin
    int             lat;
    int             d;
    logic [W-1:0]   a, b, e, mask;
    logic [2*W-1:0] p;
    logic [W:0]     bf;
    logic [2*W-1:0] ones;

    ones     = '1;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    @(negedge clk);
    rst = 1'b0;

    // (x^3+x^2+x+1) / (x^2+1) = x+1, exact
    run_op(448'hF, 225'h5, lat);
    check("f_div_5_lat", lat, 448);
    check("f_div_5_q", q, 448'h3);
    check("f_div_5_r", r, 0);
    check("f_div_5_dz", div_zero, 0);
    check("f_div_5_busy", busy, 0);

    // Started in the same cycle as the previous done
    run_op(448'hB, 225'h7, lat);
    check("b_div_7_lat", lat, 448);
    check("b_div_7_q", q, 448'h3);
    check("b_div_7_r", r, 448'h2);
    @(posedge clk);
    #1;
    check("b_div_7_done_pulse", done, 0);

    run_op({rand224(), rand224()}, '0, lat);
    check("zero_lat", lat, 1);
    check("zero_dz", div_zero, 1);
    check("zero_q", q, 0);
    check("zero_r", r, 0);
    repeat (3) @(posedge clk);
    #1;
    check("zero_dz_held", div_zero, 1);
    check("zero_done_low", done, 0);

    run_op(ones, 225'h1, lat);
    check("one_lat", lat, 448);
    check("one_q", q, ones);
    check("one_r", r, 0);
    check("one_dz_cleared", div_zero, 0);

    // Full-width divisor: degree 224
    bf = {1'b1, rand224()};
    run_op({bf, 223'b0}, bf, lat);
    check("full_q", q, ones & (448'b1 << 223));
    check("full_r", r, 0);
    e = rand224();
    run_op({bf, 223'b0} ^ {{W{1'b0}}, e}, bf, lat);
    check("full_e_q", q, ones & (448'b1 << 223));
    check("full_e_r", r, {{W{1'b0}}, e});

    // Abort mid-run; q has filled its top 100 bits by then
    start_op(ones, 225'h1);
    check("abort_busy", busy, 1);
    repeat (100) @(posedge clk);
    #1;
    check("abort_partial_q", q, ones << 348);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy_low", busy, 0);
    check("abort_done_low", done, 0);
    check("abort_q", q, 0);
    check("abort_r", r, 0);
    @(negedge clk);
    rst = 1'b0;

    // Start pulses and input changes while busy must not disturb the running operation
    start_op(448'hB, 225'h7);
    repeat (5) begin
      start    = 1'b1;
      dividend = ones;
      divisor  = '0;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_done(5, lat);
    check("busy_start_lat", lat, 448);
    check("busy_start_q", q, 448'h3);
    check("busy_start_r", r, 448'h2);
    check("busy_start_dz", div_zero, 0);

    for (int n = 0; n < 20; n++) begin
      a = rand224();
      b = rand224();
      if (b == '0) b = 1;
      p = clmul(a, b);
      run_op(p, {1'b0, b}, lat);
      check("rt_done", done, 1);
      check("rt_q", q, {{W{1'b0}}, a});
      check("rt_r", r, 0);

      d = 0;
      for (int i = 0; i < W; i++) if (b[i]) d = i;
      mask = '0;
      for (int i = 0; i < W; i++) if (i < d) mask[i] = 1'b1;
      e = rand224() & mask;
      run_op(p ^ {{W{1'b0}}, e}, {1'b0, b}, lat);
      check("rte_q", q, {{W{1'b0}}, a});
      check("rte_r", r, {{W{1'b0}}, e});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
